// File: rtl/bin_to_digits_if.sv
// Handshake bundle between a binary-to-decimal-digit converter and its requester/consumer.
// The master side issues the conversion request and consumes the digits.
interface bin_to_digits_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] value;
  logic             start;
  logic             busy;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             digit_last;
  logic             digit_ready;

  modport master (
    output value, start, digit_ready,
    input  busy, digit, digit_valid, digit_last
  );

  modport slave (
    input  value, start, digit_ready,
    output busy, digit, digit_valid, digit_last
  );
endinterface

// File: rtl/bin_to_digits.sv
// Iterative double-dabble converter: one shift per clock.
// It streams the decimal digits most-significant first, with leading zeros suppressed.
module bin_to_digits #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input logic             clock,
  input logic             reset,
  bin_to_digits_if.slave  bus
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bcd_adj = bcd_q;
    digit_d = 4'd0;

    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          bin_d   = bus.value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        bcd_d = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_EMIT;
          // Highest nonzero nibble wins; an all-zero value emits a lone 0.
          idx_d   = '0;
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_d[4*i +: 4] != 4'd0) begin
              idx_d = IW'(i);
            end
          end
        end
      end
      S_EMIT: begin
        if (bus.digit_ready) begin
          if (idx_q == '0) begin
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output registers are loaded from next-state values.
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_EMIT);
    last_d  = valid_d && (idx_d == '0);
    if (valid_d) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (IW'(i) == idx_d) begin
          digit_d = bcd_d[4*i +: 4];
        end
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.digit       = digit_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_last  = last_q;

endmodule

// File: tb/tb_bin_to_digits.sv
// Directed bench for bin_to_digits: latency, digit order, leading-zero suppression,
// backpressure, ignored starts and reset abort.
module tb_bin_to_digits;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  bin_to_digits_if #(.WIDTH(16)) bus ();

  bin_to_digits #(.WIDTH(16), .DIGITS(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) at negedges until digit_valid is seen; lat counts edges waited.
  task automatic wait_valid(inout int lat);
    while (bus.digit_valid !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // exp holds the expected digits as BCD, first-emitted digit in nibble n-1.
  task automatic run_case(input logic [15:0] val, input logic [19:0] exp, input int n,
                          input bit inject, input bit start_on_last);
    int lat;
    logic [19:0] e;
    e = exp;
    @(negedge clock);
    bus.value       = val;
    bus.start       = 1'b1;
    bus.digit_ready = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("valid_during_convert", 32'(bus.digit_valid), 32'd0);
    lat = 0;
    if (inject) begin
      bus.value = 16'd999;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      lat = 1;
      check("busy_while_ignored_start", 32'(bus.busy), 32'd1);
    end
    wait_valid(lat);
    check("first_digit_latency", 32'(lat), 32'd16);
    for (int k = 0; k < n; k++) begin
      check("digit_value", 32'(bus.digit), 32'(e[4*(n-1-k) +: 4]));
      check("digit_valid", 32'(bus.digit_valid), 32'd1);
      check("digit_last", 32'(bus.digit_last), (k == n - 1) ? 32'd1 : 32'd0);
      check("busy_during_emit", 32'(bus.busy), 32'd1);
      if (start_on_last && k == n - 1) bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
    end
    check("busy_after_last", 32'(bus.busy), 32'd0);
    check("valid_after_last", 32'(bus.digit_valid), 32'd0);
    if (start_on_last) begin
      @(negedge clock);
      check("start_on_last_ignored", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int lat;
    int hs;
    bit pat [6];
    logic [19:0] e327;

    reset           = 1'b1;
    bus.value       = '0;
    bus.start       = 1'b0;
    bus.digit_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.digit_valid), 32'd0);
    check("reset_last", 32'(bus.digit_last), 32'd0);
    check("reset_digit", 32'(bus.digit), 32'd0);
    reset = 1'b0;

    run_case(16'd46,    20'h00046, 2, 1'b0, 1'b0);
    run_case(16'd327,   20'h00327, 3, 1'b0, 1'b0);
    run_case(16'd5,     20'h00005, 1, 1'b0, 1'b0);
    run_case(16'd0,     20'h00000, 1, 1'b0, 1'b0);
    run_case(16'd65535, 20'h65535, 5, 1'b0, 1'b0);
    run_case(16'd10000, 20'h10000, 5, 1'b0, 1'b1);
    run_case(16'd46,    20'h00046, 2, 1'b1, 1'b0);

    // Backpressure: ready pattern 0,0,1,0,1,1 over the digits of 327.
    pat  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    e327 = 20'h00327;
    @(negedge clock);
    bus.value       = 16'd327;
    bus.start       = 1'b1;
    bus.digit_ready = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    lat = 0;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd16);
    hs = 0;
    for (int p = 0; p < 6; p++) begin
      bus.digit_ready = pat[p];
      check("bp_digit", 32'(bus.digit), 32'(e327[4*(2-hs) +: 4]));
      check("bp_valid", 32'(bus.digit_valid), 32'd1);
      check("bp_last", 32'(bus.digit_last), (hs == 2) ? 32'd1 : 32'd0);
      @(negedge clock);
      if (pat[p]) hs++;
    end
    check("bp_busy_done", 32'(bus.busy), 32'd0);
    check("bp_valid_done", 32'(bus.digit_valid), 32'd0);

    // Reset five edges into CONVERT.
    @(negedge clock);
    bus.value       = 16'd327;
    bus.start       = 1'b1;
    bus.digit_ready = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_conv_busy", 32'(bus.busy), 32'd0);
    check("rst_conv_valid", 32'(bus.digit_valid), 32'd0);
    check("rst_conv_digit", 32'(bus.digit), 32'd0);
    repeat (20) @(negedge clock);
    check("rst_conv_no_digits", 32'(bus.digit_valid), 32'd0);
    run_case(16'd81, 20'h00081, 2, 1'b0, 1'b0);

    // Reset after the first digit of 327 is accepted.
    @(negedge clock);
    bus.value       = 16'd327;
    bus.start       = 1'b1;
    bus.digit_ready = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    lat = 0;
    wait_valid(lat);
    check("rst_emit_first", 32'(bus.digit), 32'd3);
    bus.digit_ready = 1'b1;
    @(negedge clock);
    bus.digit_ready = 1'b0;
    check("rst_emit_second", 32'(bus.digit), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_emit_busy", 32'(bus.busy), 32'd0);
    check("rst_emit_valid", 32'(bus.digit_valid), 32'd0);
    check("rst_emit_digit", 32'(bus.digit), 32'd0);
    bus.digit_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_emit_no_digits", 32'(bus.digit_valid), 32'd0);
    run_case(16'd81, 20'h00081, 2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
